// File: rtl/neander_ctrl_fsm_if.sv
// Control-unit <-> datapath/memory signal bundle for the Neander control FSM.
// master: the control unit (drives strobes and bus requests).
// slave : the datapath/memory side (drives opcode, flags, ack and run).
interface neander_ctrl_fsm_if;
  logic [3:0] opcode;
  logic       Szero;
  logic       Snegative;
  logic       mem_ack;
  logic       run;
  logic       cgREM;
  logic       sel;
  logic       INCPC;
  logic       cgPC;
  logic       cgRDM;
  logic       selRDM;
  logic       READ;
  logic       WRITE;
  logic       cgRI;
  logic [2:0] ula_op;
  logic       cgAC;
  logic       cgNZ;
  logic       GOtoT0;
  logic       halted;
  logic       bus_err;

  modport master (
    input  opcode, Szero, Snegative, mem_ack, run,
    output cgREM, sel, INCPC, cgPC, cgRDM, selRDM, READ, WRITE, cgRI,
           ula_op, cgAC, cgNZ, GOtoT0, halted, bus_err
  );

  modport slave (
    output opcode, Szero, Snegative, mem_ack, run,
    input  cgREM, sel, INCPC, cgPC, cgRDM, selRDM, READ, WRITE, cgRI,
           ula_op, cgAC, cgNZ, GOtoT0, halted, bus_err
  );
endinterface

// File: rtl/neander_ctrl_fsm.sv
// Neander control unit: fetch/decode/execute sequencer over a req/ack memory
// bus, with bus time-out detection (ERROR) and a resumable HALT.
module neander_ctrl_fsm #(
  parameter int unsigned TIMEOUT_W   = 4,
  parameter int unsigned TIMEOUT_MAX = 15,
  parameter int unsigned RESUME_EN   = 1
) (
  input  logic                  clock,
  input  logic                  nreset,
  neander_ctrl_fsm_if.master    bus
);

  typedef enum logic [3:0] {
    S_T0, S_FETCH_R, S_LOAD_RI, S_DECODE, S_OPA_A, S_OPA_R, S_JUMP,
    S_EXA_A, S_EX_R, S_ALU, S_STA_D, S_STA_W, S_HALT, S_ERROR
  } state_t;

  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Counter value in the last allowed wait cycle; no ack here means time-out.
  localparam logic [TIMEOUT_W-1:0] LP_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;

  logic       w_wait;
  logic       w_timeout;
  logic       w_resume;
  logic       w_is_jump;
  logic       w_cgREM, w_sel, w_INCPC, w_cgPC, w_cgRDM, w_selRDM;
  logic       w_READ, w_WRITE, w_cgRI, w_cgAC, w_cgNZ, w_GOtoT0;
  logic       w_halted, w_bus_err;
  logic [2:0] w_ula_op;

  assign w_wait    = (r_state == S_FETCH_R) || (r_state == S_OPA_R) ||
                     (r_state == S_EX_R)    || (r_state == S_STA_W);
  assign w_timeout = w_wait && !bus.mem_ack && (r_wait_cnt == LP_LAST);
  assign w_resume  = (RESUME_EN != 0) && bus.run;
  assign w_is_jump = (bus.opcode == OP_JMP) || (bus.opcode == OP_JN) ||
                     (bus.opcode == OP_JZ);

  // State sequencing and bus wait counter (counter is zero outside wait states).
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_T0;
      r_wait_cnt <= '0;
    end else begin
      if (w_wait && !bus.mem_ack && !w_timeout) r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      else                                      r_wait_cnt <= '0;

      case (r_state)
        S_T0:      r_state <= S_FETCH_R;
        S_FETCH_R: if (bus.mem_ack) r_state <= S_LOAD_RI;
                   else if (w_timeout) r_state <= S_ERROR;
        S_LOAD_RI: r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_HLT:                                      r_state <= S_HALT;
            OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: r_state <= S_OPA_A;
            OP_JN:   r_state <= bus.Snegative ? S_OPA_A : S_T0;
            OP_JZ:   r_state <= bus.Szero     ? S_OPA_A : S_T0;
            default: r_state <= S_T0;
          endcase
        end
        S_OPA_A:   r_state <= S_OPA_R;
        S_OPA_R:   if (bus.mem_ack) r_state <= w_is_jump ? S_JUMP : S_EXA_A;
                   else if (w_timeout) r_state <= S_ERROR;
        S_JUMP:    r_state <= S_T0;
        S_EXA_A:   r_state <= (bus.opcode == OP_STA) ? S_STA_D : S_EX_R;
        S_EX_R:    if (bus.mem_ack) r_state <= S_ALU;
                   else if (w_timeout) r_state <= S_ERROR;
        S_ALU:     r_state <= S_T0;
        S_STA_D:   r_state <= S_STA_W;
        S_STA_W:   if (bus.mem_ack) r_state <= S_T0;
                   else if (w_timeout) r_state <= S_ERROR;
        S_HALT:    if (w_resume) r_state <= S_T0;
        S_ERROR:   if (w_resume) r_state <= S_T0;
        default:   r_state <= S_T0;
      endcase
    end
  end

  // Strobe decode. Kept combinational: ack-qualified strobes (cgRDM/INCPC) and
  // the DECODE branch/ALU strobes must appear in the same cycle as their inputs.
  always_comb begin
    w_cgREM = 1'b0; w_sel = 1'b0; w_INCPC = 1'b0; w_cgPC = 1'b0;
    w_cgRDM = 1'b0; w_selRDM = 1'b0; w_READ = 1'b0; w_WRITE = 1'b0;
    w_cgRI = 1'b0; w_ula_op = 3'd0; w_cgAC = 1'b0; w_cgNZ = 1'b0;
    w_GOtoT0 = 1'b0; w_halted = 1'b0; w_bus_err = 1'b0;
    case (r_state)
      S_T0, S_OPA_A: w_cgREM = 1'b1;
      S_FETCH_R, S_OPA_R: begin
        w_READ  = 1'b1;
        w_cgRDM = bus.mem_ack;
        w_INCPC = bus.mem_ack;
      end
      S_LOAD_RI: w_cgRI = 1'b1;
      S_DECODE: begin
        case (bus.opcode)
          OP_NOT: begin
            w_ula_op = 3'd4; w_cgAC = 1'b1; w_cgNZ = 1'b1; w_GOtoT0 = 1'b1;
          end
          OP_JN: begin
            w_INCPC = !bus.Snegative; w_GOtoT0 = !bus.Snegative;
          end
          OP_JZ: begin
            w_INCPC = !bus.Szero; w_GOtoT0 = !bus.Szero;
          end
          OP_HLT, OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP: ;
          default: w_GOtoT0 = 1'b1;
        endcase
      end
      S_JUMP: begin
        w_cgPC = 1'b1; w_GOtoT0 = 1'b1;
      end
      S_EXA_A: begin
        w_sel = 1'b1; w_cgREM = 1'b1;
      end
      S_EX_R: begin
        w_READ = 1'b1; w_cgRDM = bus.mem_ack;
      end
      S_ALU: begin
        case (bus.opcode)
          OP_ADD:  w_ula_op = 3'd1;
          OP_OR:   w_ula_op = 3'd2;
          OP_AND:  w_ula_op = 3'd3;
          default: w_ula_op = 3'd0;
        endcase
        w_cgAC = 1'b1; w_cgNZ = 1'b1; w_GOtoT0 = 1'b1;
      end
      S_STA_D: begin
        w_selRDM = 1'b1; w_cgRDM = 1'b1;
      end
      S_STA_W: begin
        w_WRITE = 1'b1; w_GOtoT0 = bus.mem_ack;
      end
      S_HALT:  w_halted  = 1'b1;
      S_ERROR: w_bus_err = 1'b1;
      default: ;
    endcase
  end

  // All strobes are forced low while reset is held.
  assign bus.cgREM   = w_cgREM   & nreset;
  assign bus.sel     = w_sel     & nreset;
  assign bus.INCPC   = w_INCPC   & nreset;
  assign bus.cgPC    = w_cgPC    & nreset;
  assign bus.cgRDM   = w_cgRDM   & nreset;
  assign bus.selRDM  = w_selRDM  & nreset;
  assign bus.READ    = w_READ    & nreset;
  assign bus.WRITE   = w_WRITE   & nreset;
  assign bus.cgRI    = w_cgRI    & nreset;
  assign bus.ula_op  = w_ula_op  & {3{nreset}};
  assign bus.cgAC    = w_cgAC    & nreset;
  assign bus.cgNZ    = w_cgNZ    & nreset;
  assign bus.GOtoT0  = w_GOtoT0  & nreset;
  assign bus.halted  = w_halted  & nreset;
  assign bus.bus_err = w_bus_err & nreset;

endmodule
